data_mem_responder: RTL

// - Multi-cycle data-memory responder: the memory-side end of the datapath's load/store interface
//   (memRead/memWrite/addrIn/dataIn/dataOut).
// - Accepts one word request at a time. Holds it for LATENCY cycles, performs the access,

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the datapath (master) and the data-memory responder (slave).
// Optional macro DMEM_ERR_EN adds the err completion flag.
interface data_mem_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addrIn;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        ready;
  logic        busy;
`ifdef DMEM_ERR_EN
  logic        err;

  modport master (output memRead, memWrite, addrIn, dataIn,
                  input  dataOut, ready, busy, err);
  modport slave  (input  memRead, memWrite, addrIn, dataIn,
                  output dataOut, ready, busy, err);
`else
  modport master (output memRead, memWrite, addrIn, dataIn,
                  input  dataOut, ready, busy);
  modport slave  (input  memRead, memWrite, addrIn, dataIn,
                  output dataOut, ready, busy);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one word request at a time, waits LATENCY
// cycles, performs the access, then pulses ready for one cycle.
// Optional macro DMEM_ERR_EN: adds err and rejects misaligned / out-of-range accesses
// instead of wrapping the address.
//
// state | meaning
// IDLE  | waiting for memRead/memWrite; request fields latched when seen
// WAIT  | counting down cnt; access executes on the edge where cnt==0
// RESP  | ready (and err, if faulty) high for this single cycle
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  s_bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_WORDS < 4 || DEPTH_WORDS > 65536 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("data_mem_responder: DEPTH_WORDS must be a power of two in 4..65536");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic               w_accept;
  logic               w_access;
  logic               r_is_write;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_dout;
  logic [31:0]        r_mem [DEPTH_WORDS];
  logic               w_fault;

`ifdef DMEM_ERR_EN
  logic r_fault;
  logic w_req_fault;

  assign w_req_fault = (s_bus.addrIn[1:0] != 2'b00) ||
                       (s_bus.addrIn >= 32'(DEPTH_WORDS * 4));
  assign w_fault     = r_fault;
  assign s_bus.err   = (r_state == RESP) && r_fault;

  // Fault status travels with the latched request.
  always_ff @(posedge clk) begin
    if (!reset)        r_fault <= 1'b0;
    else if (w_accept) r_fault <= w_req_fault;
  end
`else
  logic w_unused;

  // Address bits outside the word index are deliberately dropped (wrap-around).
  assign w_unused = ^{s_bus.addrIn[31:IDX_W+2], s_bus.addrIn[1:0]};
  assign w_fault  = 1'b0;
`endif

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; w_access marks the edge on which the memory access happens.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_bus.memRead || s_bus.memWrite) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the request so bus changes mid-flight have no effect; both-high counts as a write.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_write <= s_bus.memWrite;
      r_idx      <= s_bus.addrIn[IDX_W+1:2];
      r_wdata    <= s_bus.dataIn;
    end
  end

  // Memory write; gated by reset so a reset on the access edge drops the store.
  always_ff @(posedge clk) begin
    if (reset && w_access && r_is_write && !w_fault) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Registered load data; held until the next completed read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dout <= 32'd0;
    end else if (w_access && !r_is_write) begin
      r_dout <= w_fault ? 32'd0 : r_mem[r_idx];
    end
  end

  assign s_bus.dataOut = r_dout;
  assign s_bus.ready   = (r_state == RESP);
  assign s_bus.busy    = (r_state != IDLE);

endmodule
